// File: rtl/vga_pkg.sv
// Shared raster definitions: coordinate width, default 800x600@72 geometry
// and the scan-position struct handed to renderers.
package vga_pkg;

    localparam int COORD_W = 11;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 56;
    localparam int DEF_H_SYNC   = 120;
    localparam int DEF_H_BP     = 64;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 37;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 23;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               active;
        logic               hsync;
        logic               vsync;
    } raster_t;

endpackage

// File: rtl/span_counter.sv
// Modulo-(MAX+1) counter that resets to MAX, so the first increment lands on 0.
// Exposes its next value so the caller can register decode in lockstep.
module span_counter
    import vga_pkg::*;
#(
    parameter int MAX = 1039
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               inc_i,
    output logic [COORD_W-1:0] count_o,
    output logic [COORD_W-1:0] count_next_o,
    output logic               wrap_o
);

    localparam logic [COORD_W-1:0] MAX_C = COORD_W'(MAX);

    logic [COORD_W-1:0] count_q;
    logic [COORD_W-1:0] count_d;

    // wrap_o marks the terminal count; the next increment returns to 0.
    assign wrap_o = (count_q == MAX_C);

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = wrap_o ? '0 : count_q + COORD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= MAX_C;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: x/y scan counters with registered sync, active and
// one-cycle SOF/EOF decode, all updated on the same edge as the counters.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_en,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic        SOF,
    output logic        EOF,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [COORD_W-1:0] EOF_Y    = COORD_W'(V_ACTIVE - 1);

    logic [COORD_W-1:0] h_count, h_next;
    logic [COORD_W-1:0] v_count, v_next;
    logic               h_wrap, v_wrap;

    span_counter #(.MAX(H_TOTAL - 1)) u_h_cnt (
        .clk          (clk),
        .reset_n      (reset_n),
        .inc_i        (pix_en),
        .count_o      (h_count),
        .count_next_o (h_next),
        .wrap_o       (h_wrap)
    );

    span_counter #(.MAX(V_TOTAL - 1)) u_v_cnt (
        .clk          (clk),
        .reset_n      (reset_n),
        .inc_i        (pix_en & h_wrap),
        .count_o      (v_count),
        .count_next_o (v_next),
        .wrap_o       (v_wrap)
    );

    logic        active_q, active_d;
    logic        hsync_q,  hsync_d;
    logic        vsync_q,  vsync_d;
    logic        sof_q,    sof_d;
    logic        eof_q,    eof_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Decode the position the counters are about to hold, so the registered
    // flags line up with x/y in every cycle.
    always_comb begin
        active_d    = (h_next < H_ACT_C) && (v_next < V_ACT_C);
        hsync_d     = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? H_POL : ~H_POL;
        vsync_d     = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? V_POL : ~V_POL;
        sof_d       = pix_en & h_wrap & v_wrap;
        eof_d       = pix_en && (h_next == H_ACT_C) && (v_next == EOF_Y);
        frame_cnt_d = frame_cnt_q;
        if (sof_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_q    <= 1'b0;
            hsync_q     <= ~H_POL;
            vsync_q     <= ~V_POL;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            active_q    <= active_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    raster_t raster;
    assign raster = '{x: h_count, y: v_count, active: active_q, hsync: hsync_q, vsync: vsync_q};

    assign x         = raster.x;
    assign y         = raster.y;
    assign active    = raster.active;
    assign hsync     = raster.hsync;
    assign vsync     = raster.vsync;
    assign SOF       = sof_q;
    assign EOF       = eof_q;
    assign frame_cnt = frame_cnt_q;

endmodule
